b06_requester: RTL and testbench

Initiator side of the b06 interrupt-handler handshake. It queues upstream events, raises EQL toward the handler, and waits for ACKOUT. Once acknowledged, it runs a service counter gated by ENABLE_COUNT and raises CONT_EQL at the programmed match. On completion it captures the handler's USCITE/CC_MUX result code and retires one pending event. It sits between the event sources and the b06 handler, in the same synchronous clock domain.

---
 rtl/b06_pkg.sv | 20 ++
 rtl/b06_pend_counter.sv | 45 ++++
 rtl/b06_requester.sv | 161 ++++++++++++++++
 tb/tb_b06_requester.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b06_pkg.sv
// Shared state encoding, result-code type and width defaults for the b06 requester.
package b06_pkg;

    localparam int unsigned PEND_W_DEF = 3;
    localparam int unsigned CNT_W_DEF  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StServe,
        StMatch,
        StRetire
    } b06_state_e;

    typedef struct packed {
        logic [1:0] cc_mux;
        logic [1:0] uscite;
    } b06_code_t;

endpackage

// File: rtl/b06_pend_counter.sv
// Saturating up/down counter with a sticky overflow flag for queued events.
module b06_pend_counter #(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;
    logic         r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            // Simultaneous inc and dec cancel, so no overflow can occur then.
            unique case ({i_inc, i_dec})
                2'b10: begin
                    if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                2'b01: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/b06_requester.sv
// Initiator side of the b06 interrupt-handler handshake.
// Define B06REQ_TIMEOUT_EN to add the ACKOUT timeout with sticky ERR and request retry.
module b06_requester
    import b06_pkg::*;
#(
    parameter int unsigned PEND_W    = PEND_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned CNT_MATCH = 5,
    parameter int unsigned TO_CYC    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              REQ_IN,
    input  logic              ACKOUT,
    input  logic              ENABLE_COUNT,
    input  logic [1:0]        USCITE,
    input  logic [1:0]        CC_MUX,
    output logic              EQL,
    output logic              CONT_EQL,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND_CNT,
    output logic              DONE,
    output logic [3:0]        SERVICED_CODE,
    output logic              OVF,
    output logic              ERR
);

    localparam logic [CNT_W-1:0] MATCH_VAL = CNT_W'(CNT_MATCH);

    b06_state_e       r_state;
    logic [CNT_W-1:0] r_svc_cnt;
    logic             r_eql;
    logic             r_cont_eql;
    logic             r_busy;
    logic             r_done;
    b06_code_t        r_code;

    logic w_retire;
    logic w_pend_nz;

`ifdef B06REQ_TIMEOUT_EN
    localparam int unsigned    TO_W    = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
`endif

    // Retirement is the edge that leaves MATCH; the pending count drops on that same edge.
    assign w_retire  = (r_state == StMatch) && !ENABLE_COUNT;
    assign w_pend_nz = |PEND_CNT;

    b06_pend_counter #(
        .W (PEND_W)
    ) u_pend_counter (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_inc   (REQ_IN),
        .i_dec   (w_retire),
        .o_cnt   (PEND_CNT),
        .o_ovf   (OVF)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_svc_cnt  <= '0;
            r_eql      <= 1'b0;
            r_cont_eql <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_code     <= '0;
`ifdef B06REQ_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pend_nz) begin
                        r_state <= StReq;
                        r_eql   <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef B06REQ_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                StReq: begin
                    if (ACKOUT) begin
                        r_state   <= StServe;
                        r_eql     <= 1'b0;
                        r_svc_cnt <= '0;
                    end
`ifdef B06REQ_TIMEOUT_EN
                    // Drop through IDLE for one cycle; the event stays queued and is retried.
                    else if (r_to_cnt == TO_LAST) begin
                        r_state <= StIdle;
                        r_eql   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                StServe: begin
                    if (ENABLE_COUNT) begin
                        if (r_svc_cnt == MATCH_VAL) begin
                            r_state    <= StMatch;
                            r_cont_eql <= 1'b1;
                        end else begin
                            r_svc_cnt <= r_svc_cnt + 1'b1;
                        end
                    end
                end
                StMatch: begin
                    if (!ENABLE_COUNT) begin
                        r_state       <= StRetire;
                        r_cont_eql    <= 1'b0;
                        r_done        <= 1'b1;
                        r_code.cc_mux <= CC_MUX;
                        r_code.uscite <= USCITE;
                    end
                end
                StRetire: begin
                    if (w_pend_nz) begin
                        r_state <= StReq;
                        r_eql   <= 1'b1;
`ifdef B06REQ_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_eql      <= 1'b0;
                    r_cont_eql <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign EQL           = r_eql;
    assign CONT_EQL      = r_cont_eql;
    assign BUSY          = r_busy;
    assign DONE          = r_done;
    assign SERVICED_CODE = r_code;

`ifdef B06REQ_TIMEOUT_EN
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_b06_requester.sv
// Self-checking bench for b06_requester: directed scenarios plus a randomized handler
// with a protocol-level reference model; honours B06REQ_TIMEOUT_EN when defined.
module tb_b06_requester;

    localparam int unsigned PEND_W    = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned CNT_MATCH = 5;
    localparam int unsigned TO_CYC    = 16;
    localparam int          PEND_MAX  = (1 << PEND_W) - 1;

    logic              clock        = 1'b0;
    logic              reset        = 1'b0;
    logic              REQ_IN       = 1'b0;
    logic              ACKOUT       = 1'b0;
    logic              ENABLE_COUNT = 1'b0;
    logic [1:0]        USCITE       = 2'b00;
    logic [1:0]        CC_MUX       = 2'b00;
    logic              EQL;
    logic              CONT_EQL;
    logic              BUSY;
    logic [PEND_W-1:0] PEND_CNT;
    logic              DONE;
    logic [3:0]        SERVICED_CODE;
    logic              OVF;
    logic              ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    b06_requester #(
        .PEND_W    (PEND_W),
        .CNT_W     (CNT_W),
        .CNT_MATCH (CNT_MATCH),
        .TO_CYC    (TO_CYC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .REQ_IN        (REQ_IN),
        .ACKOUT        (ACKOUT),
        .ENABLE_COUNT  (ENABLE_COUNT),
        .USCITE        (USCITE),
        .CC_MUX        (CC_MUX),
        .EQL           (EQL),
        .CONT_EQL      (CONT_EQL),
        .BUSY          (BUSY),
        .PEND_CNT      (PEND_CNT),
        .DONE          (DONE),
        .SERVICED_CODE (SERVICED_CODE),
        .OVF           (OVF),
        .ERR           (ERR)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        REQ_IN = 0; ACKOUT = 0; ENABLE_COUNT = 0; USCITE = 0; CC_MUX = 0;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        tick();
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            REQ_IN = 1;
            tick();
        end
        REQ_IN = 0;
    endtask

    task automatic wait_eql(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (EQL === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_ack();
        ACKOUT = 1;
        tick();
        ACKOUT = 0;
    endtask

    // Drives ENABLE_COUNT in SERVE until CONT_EQL shows; counts edges that saw enable high.
    task automatic run_serve(input bit toggle, output int en_edges, output int edges,
                             output bit ok);
        en_edges = 0; edges = 0; ok = 0;
        for (int i = 0; i < 64; i++) begin
            ENABLE_COUNT = toggle ? ~i[0] : 1'b1;
            tick();
            edges++;
            if (ENABLE_COUNT) en_edges++;
            if (CONT_EQL === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic serve_to_match(output bit ok);
        bit okw, oks;
        int en, ed;
        wait_eql(okw);
        pulse_ack();
        run_serve(1'b0, en, ed, oks);
        ok = okw && oks && (en == CNT_MATCH + 1);
    endtask

    task automatic do_retire(input logic [3:0] code, input logic req);
        CC_MUX = code[3:2]; USCITE = code[1:0]; ENABLE_COUNT = 0; REQ_IN = req;
        tick();
        REQ_IN = 0;
    endtask

    task automatic test_reset();
        reset = 0; REQ_IN = 1; ACKOUT = 1; ENABLE_COUNT = 1; USCITE = 2'b11; CC_MUX = 2'b11;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({EQL, CONT_EQL, BUSY, DONE, OVF, ERR, PEND_CNT, SERVICED_CODE} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b, want all zero",
                     {EQL, CONT_EQL, BUSY, DONE, OVF, ERR, PEND_CNT, SERVICED_CODE});
        end
        REQ_IN = 0; ACKOUT = 0; ENABLE_COUNT = 0; USCITE = 0; CC_MUX = 0;
        @(negedge clock);
        reset = 1;
        tick();
        n_cmp++;
        if ({EQL, CONT_EQL, BUSY, DONE, OVF, ERR, PEND_CNT, SERVICED_CODE} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %b, want all zero",
                     {EQL, CONT_EQL, BUSY, DONE, OVF, ERR, PEND_CNT, SERVICED_CODE});
        end
    endtask

    task automatic test_single();
        bit ok;
        int en, ed;
        apply_reset();
        strobe(1);
        n_cmp++;
        if (EQL !== 1'b0 || PEND_CNT !== 3'd1) begin
            n_fail++;
            $display("FAIL single_pend: EQL=%b PEND_CNT=%0d, want EQL=0 PEND_CNT=1", EQL, PEND_CNT);
        end
        tick();
        n_cmp++;
        if (EQL !== 1'b1 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL single_eql_latency: EQL=%b BUSY=%b, want 1 1", EQL, BUSY);
        end
        tick();
        ENABLE_COUNT = 1;
        pulse_ack();
        n_cmp++;
        if (EQL !== 1'b0 || BUSY !== 1'b1 || CONT_EQL !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: EQL=%b BUSY=%b CONT_EQL=%b, want 0 1 0", EQL, BUSY, CONT_EQL);
        end
        run_serve(1'b0, en, ed, ok);
        n_cmp++;
        if (!ok || ed != CNT_MATCH + 1) begin
            n_fail++;
            $display("FAIL single_match_latency: seen=%0d edges=%0d, want seen=1 edges=%0d",
                     ok, ed, CNT_MATCH + 1);
        end
        ACKOUT = 1;
        repeat (3) tick();
        ACKOUT = 0;
        n_cmp++;
        if (CONT_EQL !== 1'b1 || DONE !== 1'b0 || EQL !== 1'b0) begin
            n_fail++;
            $display("FAIL match_hold: CONT_EQL=%b DONE=%b EQL=%b, want 1 0 0", CONT_EQL, DONE, EQL);
        end
        do_retire(4'b1001, 1'b0);
        n_cmp++;
        if (DONE !== 1'b1 || SERVICED_CODE !== 4'b1001 || CONT_EQL !== 1'b0 || PEND_CNT !== 3'd0) begin
            n_fail++;
            $display("FAIL single_retire: DONE=%b CODE=%b CONT_EQL=%b PEND=%0d, want 1 1001 0 0",
                     DONE, SERVICED_CODE, CONT_EQL, PEND_CNT);
        end
        tick();
        n_cmp++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || EQL !== 1'b0 || SERVICED_CODE !== 4'b1001) begin
            n_fail++;
            $display("FAIL single_idle: DONE=%b BUSY=%b EQL=%b CODE=%b, want 0 0 0 1001",
                     DONE, BUSY, EQL, SERVICED_CODE);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] code;
        apply_reset();
        strobe(3);
        n_cmp++;
        if (PEND_CNT !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_queue: PEND_CNT=%0d, want 3", PEND_CNT);
        end
        for (int k = 0; k < 3; k++) begin
            serve_to_match(ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_serve_%0d: match reached=%0d, want 1", k, ok);
            end
            code = 4'($urandom_range(0, 15));
            do_retire(code, 1'b0);
            n_cmp++;
            if (DONE !== 1'b1 || SERVICED_CODE !== code || PEND_CNT !== 3'(2 - k)) begin
                n_fail++;
                $display("FAIL b2b_retire_%0d: DONE=%b CODE=%h PEND=%0d, want 1 %h %0d",
                         k, DONE, SERVICED_CODE, PEND_CNT, code, 2 - k);
            end
            tick();
            n_cmp++;
            if (EQL !== (k < 2) || BUSY !== (k < 2) || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_after_%0d: EQL=%b BUSY=%b DONE=%b, want %0d %0d 0",
                         k, EQL, BUSY, DONE, k < 2, k < 2);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        strobe(7);
        n_cmp++;
        if (PEND_CNT !== 3'd7 || OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: PEND=%0d OVF=%b, want 7 0", PEND_CNT, OVF);
        end
        strobe(1);
        n_cmp++;
        if (PEND_CNT !== 3'd7 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: PEND=%0d OVF=%b, want 7 1", PEND_CNT, OVF);
        end
        apply_reset();
        strobe(7);
        serve_to_match(ok);
        do_retire(4'b0110, 1'b1);
        n_cmp++;
        if (!ok || PEND_CNT !== 3'd7 || OVF !== 1'b0 || DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_coincident_max: ok=%0d PEND=%0d OVF=%b DONE=%b, want 1 7 0 1",
                     ok, PEND_CNT, OVF, DONE);
        end
        tick();
        serve_to_match(ok);
        do_retire(4'b0011, 1'b0);
        n_cmp++;
        if (!ok || PEND_CNT !== 3'd6) begin
            n_fail++;
            $display("FAIL ovf_plain_retire: ok=%0d PEND=%0d, want 1 6", ok, PEND_CNT);
        end
        tick();
        serve_to_match(ok);
        do_retire(4'b1100, 1'b1);
        n_cmp++;
        if (!ok || PEND_CNT !== 3'd6 || OVF !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_coincident_6: ok=%0d PEND=%0d OVF=%b, want 1 6 0", ok, PEND_CNT, OVF);
        end
    endtask

    task automatic test_toggle();
        bit ok, okw;
        int en, ed;
        apply_reset();
        strobe(1);
        wait_eql(okw);
        pulse_ack();
        run_serve(1'b1, en, ed, ok);
        n_cmp++;
        if (!okw || !ok || en != CNT_MATCH + 1 || ed != 2 * CNT_MATCH + 1) begin
            n_fail++;
            $display("FAIL toggle_enable: seen=%0d enabled=%0d edges=%0d, want 1 %0d %0d",
                     ok, en, ed, CNT_MATCH + 1, 2 * CNT_MATCH + 1);
        end
        do_retire(4'b0101, 1'b0);
        n_cmp++;
        if (DONE !== 1'b1 || SERVICED_CODE !== 4'b0101) begin
            n_fail++;
            $display("FAIL toggle_retire: DONE=%b CODE=%b, want 1 0101", DONE, SERVICED_CODE);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        apply_reset();
        strobe(2);
        serve_to_match(ok);
        n_cmp++;
        if (!ok || CONT_EQL !== 1'b1 || BUSY !== 1'b1 || PEND_CNT !== 3'd2) begin
            n_fail++;
            $display("FAIL async_pre: ok=%0d CONT_EQL=%b BUSY=%b PEND=%0d, want 1 1 1 2",
                     ok, CONT_EQL, BUSY, PEND_CNT);
        end
        #2;
        reset = 0;
        #1;
        n_cmp++;
        if ({CONT_EQL, EQL, BUSY, DONE, PEND_CNT} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: CONT_EQL=%b EQL=%b BUSY=%b DONE=%b PEND=%0d, want all 0",
                     CONT_EQL, EQL, BUSY, DONE, PEND_CNT);
        end
        ENABLE_COUNT = 0;
        @(negedge clock);
        reset = 1;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset();
        strobe(1);
        wait_eql(ok);
`ifdef B06REQ_TIMEOUT_EN
        begin
            int hi;
            bit err_early;
            hi = 0; err_early = 0;
            for (int i = 0; i < 40; i++) begin
                if (EQL !== 1'b1) break;
                hi++;
                err_early |= (ERR === 1'b1);
                tick();
            end
            n_cmp++;
            if (!ok || hi != TO_CYC || err_early) begin
                n_fail++;
                $display("FAIL timeout_len: EQL high %0d cycles early_err=%0d, want %0d 0",
                         hi, err_early, TO_CYC);
            end
            n_cmp++;
            if (EQL !== 1'b0 || ERR !== 1'b1 || PEND_CNT !== 3'd1) begin
                n_fail++;
                $display("FAIL timeout_drop: EQL=%b ERR=%b PEND=%0d, want 0 1 1", EQL, ERR, PEND_CNT);
            end
            tick();
            n_cmp++;
            if (EQL !== 1'b1 || ERR !== 1'b1 || PEND_CNT !== 3'd1) begin
                n_fail++;
                $display("FAIL timeout_retry: EQL=%b ERR=%b PEND=%0d, want 1 1 1", EQL, ERR, PEND_CNT);
            end
        end
`else
        repeat (40) tick();
        n_cmp++;
        if (!ok || EQL !== 1'b1 || ERR !== 1'b0 || PEND_CNT !== 3'd1) begin
            n_fail++;
            $display("FAIL no_timeout: EQL=%b ERR=%b PEND=%0d, want 1 0 1", EQL, ERR, PEND_CNT);
        end
`endif
    endtask

    // Bench plays the handler at random; expectations come from the queueing rules.
    task automatic test_random();
        int exp_pend, hphase, delay, en_edges, retires;
        bit exp_ovf, ret;
        logic [3:0] code;
        apply_reset();
        exp_pend = 0; exp_ovf = 0; hphase = 0; delay = 0; en_edges = 0; retires = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            REQ_IN = ($urandom_range(0, 5) == 0);
            ACKOUT = 0;
            ret = 0;
            code = 4'($urandom_range(0, 15));
            CC_MUX = code[3:2];
            USCITE = code[1:0];
            ENABLE_COUNT = ($urandom_range(0, 3) != 0);
            if (hphase == 0) begin
                if (EQL === 1'b1) begin
                    hphase = 1;
                    delay = $urandom_range(0, 3);
                end else begin
                    ACKOUT = ($urandom_range(0, 7) == 0);
                end
            end
            if (hphase == 1) begin
                if (delay == 0) begin
                    ACKOUT = 1;
                    hphase = 2;
                    en_edges = 0;
                end else begin
                    delay--;
                end
            end else if (hphase == 2) begin
                ACKOUT = ($urandom_range(0, 7) == 0);
                if (ENABLE_COUNT) en_edges++;
            end else if (hphase == 3) begin
                ACKOUT = ($urandom_range(0, 7) == 0);
                ENABLE_COUNT = ($urandom_range(0, 1) != 0);
                ret = !ENABLE_COUNT;
            end
            if (REQ_IN && !ret) begin
                if (exp_pend == PEND_MAX) exp_ovf = 1;
                else exp_pend++;
            end else if (ret && !REQ_IN) begin
                exp_pend--;
            end
            tick();
            n_cmp++;
            if (PEND_CNT !== PEND_W'(exp_pend) || OVF !== exp_ovf) begin
                n_fail++;
                $display("FAIL rnd_pend cyc %0d: PEND=%0d OVF=%b, want %0d %b",
                         cyc, PEND_CNT, OVF, exp_pend, exp_ovf);
            end
            n_cmp++;
            if (DONE !== ret) begin
                n_fail++;
                $display("FAIL rnd_done cyc %0d: DONE=%b, want %b", cyc, DONE, ret);
            end
            if (ret) begin
                n_cmp++;
                if (SERVICED_CODE !== code || CONT_EQL !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_code cyc %0d: CODE=%h CONT_EQL=%b, want %h 0",
                             cyc, SERVICED_CODE, CONT_EQL, code);
                end
                hphase = 0;
                retires++;
            end else if (hphase == 3) begin
                n_cmp++;
                if (CONT_EQL !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_match_hold cyc %0d: CONT_EQL=%b, want 1", cyc, CONT_EQL);
                end
            end
            if (hphase == 2) begin
                if (CONT_EQL === 1'b1) begin
                    n_cmp++;
                    if (en_edges != CNT_MATCH + 1) begin
                        n_fail++;
                        $display("FAIL rnd_match_count cyc %0d: enabled=%0d, want %0d",
                                 cyc, en_edges, CNT_MATCH + 1);
                    end
                    hphase = 3;
                end else if (en_edges > CNT_MATCH + 1) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rnd_no_match cyc %0d: enabled=%0d CONT_EQL=%b, want match at %0d",
                             cyc, en_edges, CONT_EQL, CNT_MATCH + 1);
                    hphase = 4;
                end
            end
        end
        n_cmp++;
        if (retires < 20) begin
            n_fail++;
            $display("FAIL rnd_progress: retirements=%0d, want at least 20", retires);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_toggle();
        test_async_reset();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
